// File: rtl/msg_char_sequencer.sv
// msg_char_sequencer: streams one of NUM_MSG fixed ASCII messages, one
// character per accepted valid/ready beat, in one-shot or loop mode.
module msg_char_sequencer #(
  parameter int DATA_W  = 8,
  parameter int NUM_MSG = 4,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8,
  localparam int IDX_W  = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        select,
  input  logic              mode,
  input  logic              q_ready,
  output logic [DATA_W-1:0] q_out,
  output logic              q_valid,
  output logic              sof,
  output logic              eof,
  output logic [IDX_W-1:0]  char_idx,
  output logic              busy,
  output logic              msg_done,
  output logic [CNT_W-1:0]  msg_count
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t             state_q, state_n;
  logic [1:0]         sel_q, sel_n;
  logic               mode_q, mode_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic               valid_q, valid_n;
  logic               done_q, done_n;
  logic [CNT_W-1:0]   count_q, count_n;
  logic [DATA_W-1:0]  q_out_q, q_out_n;
  logic               sof_q, sof_n;
  logic               eof_q, eof_n;
  logic               xfer;

  // Selects outside the populated ROM fall back to message 0.
  function automatic logic [1:0] map_sel(input logic [1:0] s);
    return (int'(s) >= NUM_MSG) ? 2'd0 : s;
  endfunction

  // Index of the final character of each message.
  function automatic logic [IDX_W-1:0] last_idx(input logic [1:0] s);
    case (int'(s))
      0:       return IDX_W'(8);  // Guatemala
      1:       return IDX_W'(6);  // Quetzal
      2:       return IDX_W'(5);  // Zacapa
      default: return IDX_W'(4);  // Tikal
    endcase
  endfunction

  // Character ROM; unused positions read as zero.
  function automatic logic [7:0] rom_char(input logic [1:0] s, input logic [IDX_W-1:0] i);
    logic [7:0] ch;
    ch = 8'h00;
    case (int'(s))
      0: case (int'(i))
           0: ch = 8'h47; 1: ch = 8'h75; 2: ch = 8'h61; 3: ch = 8'h74; 4: ch = 8'h65;
           5: ch = 8'h6D; 6: ch = 8'h61; 7: ch = 8'h6C; 8: ch = 8'h61;
           default: ch = 8'h00;
         endcase
      1: case (int'(i))
           0: ch = 8'h51; 1: ch = 8'h75; 2: ch = 8'h65; 3: ch = 8'h74; 4: ch = 8'h7A;
           5: ch = 8'h61; 6: ch = 8'h6C;
           default: ch = 8'h00;
         endcase
      2: case (int'(i))
           0: ch = 8'h5A; 1: ch = 8'h61; 2: ch = 8'h63; 3: ch = 8'h61; 4: ch = 8'h70;
           5: ch = 8'h61;
           default: ch = 8'h00;
         endcase
      default: case (int'(i))
           0: ch = 8'h54; 1: ch = 8'h69; 2: ch = 8'h6B; 3: ch = 8'h61; 4: ch = 8'h6C;
           default: ch = 8'h00;
         endcase
    endcase
    return ch;
  endfunction

  // Next-state logic: message start, character advance, boundary, abort.
  // NOTE: every variable gets a default at the top so no path can infer a latch.
  always_comb begin
    state_n = state_q;
    sel_n   = sel_q;
    mode_n  = mode_q;
    idx_n   = idx_q;
    valid_n = 1'b0;
    done_n  = 1'b0;
    count_n = count_q;
    xfer    = valid_q & q_ready;
    case (state_q)
      ST_IDLE: begin
        if (start && en && !stop) begin
          state_n = ST_STREAM;
          sel_n   = map_sel(select);
          mode_n  = mode;
          idx_n   = '0;
          valid_n = 1'b1;
        end
      end
      ST_STREAM: begin
        if (stop) begin
          state_n = ST_IDLE;
          idx_n   = '0;
        end else if (xfer && (idx_q == last_idx(sel_q))) begin
          done_n  = 1'b1;
          count_n = count_q + CNT_W'(1);
          idx_n   = '0;
          if (mode_q) begin
            sel_n   = map_sel(select);
            mode_n  = mode;
            valid_n = en;
          end else begin
            state_n = ST_IDLE;
          end
        end else if (xfer) begin
          idx_n   = idx_q + IDX_W'(1);
          valid_n = en;
        end else begin
          valid_n = en;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Registered output values derived from the next position.
  always_comb begin
    q_out_n = '0;
    if (state_n == ST_STREAM) q_out_n = DATA_W'(rom_char(sel_n, idx_n));
    sof_n = valid_n && (idx_n == '0);
    eof_n = valid_n && (idx_n == last_idx(sel_n));
  end

  // State and output registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'd0;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      q_out_q <= '0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      sel_q   <= sel_n;
      mode_q  <= mode_n;
      idx_q   <= idx_n;
      valid_q <= valid_n;
      done_q  <= done_n;
      count_q <= count_n;
      q_out_q <= q_out_n;
      sof_q   <= sof_n;
      eof_q   <= eof_n;
    end
  end

  assign q_out     = q_out_q;
  assign q_valid   = valid_q;
  assign sof       = sof_q;
  assign eof       = eof_q;
  assign char_idx  = idx_q;
  assign busy      = (state_q == ST_STREAM);
  assign msg_done  = done_q;
  assign msg_count = count_q;

endmodule

// File: tb/tb_msg_char_sequencer.sv
// tb_msg_char_sequencer: directed and random stimulus against a string-based
// reference model of the message sequencer.
module tb_msg_char_sequencer;
  localparam int DATA_W = 8;
  localparam int IDX_W  = 4;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic reset, en, start, stop, mode, q_ready;
  logic [1:0] select;

  logic [DATA_W-1:0] q_out, q_out2;
  logic              q_valid, q_valid2, sof, sof2, eof, eof2, busy, busy2;
  logic              msg_done, msg_done2;
  logic [IDX_W-1:0]  char_idx, char_idx2;
  logic [CNT_W-1:0]  msg_count, msg_count2;

  msg_char_sequencer dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .stop(stop),
    .select(select), .mode(mode), .q_ready(q_ready),
    .q_out(q_out), .q_valid(q_valid), .sof(sof), .eof(eof),
    .char_idx(char_idx), .busy(busy), .msg_done(msg_done), .msg_count(msg_count)
  );

  msg_char_sequencer #(.NUM_MSG(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .start(start), .stop(stop),
    .select(select), .mode(mode), .q_ready(q_ready),
    .q_out(q_out2), .q_valid(q_valid2), .sof(sof2), .eof(eof2),
    .char_idx(char_idx2), .busy(busy2), .msg_done(msg_done2), .msg_count(msg_count2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: which message is playing and where in it we are.
  bit    m_active, m_loop, m_valid, m_done;
  string m_msg;
  int    m_pos, m_count, dones;
  logic [7:0] acc_q[$];
  logic [7:0] acc2_q[$];

  function automatic string msg_of(input int s, input int nmsg);
    int k;
    k = (s >= nmsg) ? 0 : s;
    case (k)
      0:       return "Guatemala";
      1:       return "Quetzal";
      2:       return "Zacapa";
      default: return "Tikal";
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stream(input string tag, input string exp, input logic [7:0] q[$]);
    bit ok;
    ok = (q.size() == exp.len());
    for (int i = 0; ok && i < exp.len(); i++) if (q[i] !== exp[i]) ok = 0;
    total++;
    assert (ok) else begin
      bad++;
      $error("FAIL %s observed_len=%0d expected=%s", tag, q.size(), exp);
    end
  endtask

  // One clock: record accepted beats, advance the model, compare outputs.
  task automatic cycle();
    bit xfer;
    xfer = m_valid && q_ready;
    if (q_valid && q_ready && !stop && !reset) acc_q.push_back(q_out);
    if (q_valid2 && q_ready && !stop && !reset) acc2_q.push_back(q_out2);
    @(posedge clk);
    m_done = 0;
    if (reset) begin
      m_active = 0; m_valid = 0; m_pos = 0; m_count = 0;
    end else if (!m_active) begin
      m_valid = 0;
      if (start && en && !stop) begin
        m_active = 1; m_valid = 1; m_pos = 0;
        m_msg = msg_of(int'(select), 4); m_loop = mode;
      end
    end else if (stop) begin
      m_active = 0; m_valid = 0; m_pos = 0;
    end else if (xfer && m_pos == m_msg.len() - 1) begin
      m_done = 1; m_count = (m_count + 1) % 256; m_pos = 0;
      if (m_loop) begin
        m_msg = msg_of(int'(select), 4); m_loop = mode; m_valid = en;
      end else begin
        m_active = 0; m_valid = 0;
      end
    end else begin
      if (xfer) m_pos++;
      m_valid = en;
    end
    if (m_done) dones++;
    #1;
    check("q_valid", q_valid, m_valid);
    check("busy", busy, m_active);
    check("msg_done", msg_done, m_done);
    check("msg_count", msg_count, m_count);
    if (m_valid) begin
      check("q_out", q_out, m_msg[m_pos]);
      check("char_idx", char_idx, m_pos);
      check("sof", sof, m_pos == 0);
      check("eof", eof, m_pos == m_msg.len() - 1);
    end else begin
      check("sof_idle", sof, 0);
      check("eof_idle", eof, 0);
    end
  endtask

  task automatic wait_pos(input int p, input int budget);
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (m_valid && m_pos == p) return;
    end
    total++; bad++;
    $error("FAIL timeout_pos observed=none expected=%0d", p);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (!m_active) return;
    end
    total++; bad++;
    $error("FAIL timeout_idle observed=busy expected=idle");
  endtask

  task automatic wait_dones(input int n, input int budget);
    int target;
    target = dones + n;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (dones >= target) return;
    end
    total++; bad++;
    $error("FAIL timeout_done observed=%0d expected=%0d", dones, target);
  endtask

  task automatic do_reset();
    reset = 1; cycle(); cycle(); reset = 0;
  endtask

  initial begin
    int cnt_before;
    en = 1; start = 0; stop = 0; select = 0; mode = 0; q_ready = 1; reset = 1;
    m_active = 0; m_valid = 0; m_done = 0; m_pos = 0; m_count = 0; m_loop = 0; dones = 0;
    m_msg = "Guatemala";
    do_reset();
    check("rst_q_out", q_out, 0);
    check("rst_char_idx", char_idx, 0);

    // Test 1: one-shot message 0 at full rate.
    acc_q.delete();
    start = 1; cycle(); start = 0;
    check("t1_first", q_out, 8'h47);
    wait_idle(20);
    cycle();
    check_stream("t1_stream", "Guatemala", acc_q);
    check("t1_count", msg_count, 1);

    // Test 2: message 1 with random backpressure.
    acc_q.delete();
    select = 1; start = 1; cycle(); start = 0;
    for (int i = 0; i < 200 && m_active; i++) begin
      q_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    q_ready = 1; cycle();
    check_stream("t2_stream", "Quetzal", acc_q);

    // Test 3: loop mode, select changes mid-message take effect at the boundary.
    acc_q.delete();
    mode = 1; select = 1; start = 1; cycle(); start = 0;
    wait_pos(3, 20);
    select = 2;
    wait_dones(2, 40);
    stop = 1; cycle(); stop = 0; mode = 0;
    check_stream("t3_stream", "QuetzalZacapa", acc_q);

    // Test 4: en low for three cycles, stream resumes at 0x65.
    acc_q.delete();
    select = 0; start = 1; cycle(); start = 0;
    wait_pos(3, 20);
    en = 0;
    repeat (3) cycle();
    en = 1; cycle();
    check("t4_resume", q_out, 8'h65);
    wait_idle(20);
    check_stream("t4_stream", "Guatemala", acc_q);

    // Test 5: abort mid-message, then reset mid-message.
    cnt_before = m_count;
    start = 1; cycle(); start = 0;
    wait_pos(2, 20);
    stop = 1; cycle(); stop = 0;
    check("t5_stop_valid", q_valid, 0);
    check("t5_stop_done", msg_done, 0);
    check("t5_stop_count", msg_count, cnt_before);
    start = 1; cycle(); start = 0;
    wait_pos(5, 20);
    reset = 1; cycle(); reset = 0;
    check("t5_rst_q_out", q_out, 0);
    check("t5_rst_idx", char_idx, 0);
    check("t5_rst_count", msg_count, 0);
    check("t5_rst_busy", busy, 0);

    // Test 6: loop message 3 until the counter wraps.
    mode = 1; select = 3; start = 1; cycle(); start = 0;
    wait_dones(255, 255 * 6);
    check("t6_count255", msg_count, 255);
    wait_dones(1, 10);
    check("t6_wrap", msg_count, 0);
    stop = 1; cycle(); stop = 0; mode = 0;

    // Out-of-range select on a two-message build plays message 0.
    do_reset();
    acc_q.delete(); acc2_q.delete();
    select = 3; start = 1; cycle(); start = 0;
    repeat (12) cycle();
    check_stream("t6_sel_dut", "Tikal", acc_q);
    check_stream("t6_sel_nummsg2", "Guatemala", acc2_q);

    // Random control traffic.
    for (int i = 0; i < 500; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      start   = ($urandom_range(0, 2) == 0);
      stop    = ($urandom_range(0, 19) == 0);
      q_ready = ($urandom_range(0, 4) < 3);
      select  = 2'($urandom_range(0, 3));
      mode    = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
